// File: rtl/lcd_axil_cmd_regs.sv
// rtl/lcd_axil_cmd_regs.sv - AXI4-Lite register block feeding an LCD command FIFO stream

module lcd_cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push, pop;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign s_tready = !full;
    assign m_tvalid = !empty;
    assign m_tdata  = mem_q[rd_ptr_q];
    assign level    = level_q;

    // Full is judged before any same-edge pop, so a pop never makes room for a push.
    assign push = s_tvalid && s_tready;
    assign pop  = m_tvalid && m_tready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_tdata;
    end
endmodule

module lcd_axil_cmd_regs #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [ADDR_WIDTH-1:0] s00_axi_awaddr,
    input  logic [2:0]            s00_axi_awprot,
    input  logic                  s00_axi_awvalid,
    output logic                  s00_axi_awready,
    input  logic [31:0]           s00_axi_wdata,
    input  logic [3:0]            s00_axi_wstrb,
    input  logic                  s00_axi_wvalid,
    output logic                  s00_axi_wready,
    output logic [1:0]            s00_axi_bresp,
    output logic                  s00_axi_bvalid,
    input  logic                  s00_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s00_axi_araddr,
    input  logic [2:0]            s00_axi_arprot,
    input  logic                  s00_axi_arvalid,
    output logic                  s00_axi_arready,
    output logic [31:0]           s00_axi_rdata,
    output logic [1:0]            s00_axi_rresp,
    output logic                  s00_axi_rvalid,
    input  logic                  s00_axi_rready,
    output logic                  cmd_valid,
    output logic                  cmd_rs,
    output logic [7:0]            cmd_data,
    input  logic                  cmd_ready,
    input  logic                  lcd_busy
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0] A_CMD = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_SCRATCH = 2'd3;

    logic        run_q, run_d;
    logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [1:0]  awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ctrl_en_q, ctrl_en_d;
    logic [31:0] scratch_q, scratch_d;
    logic        ovf_q, ovf_d;

    logic        aw_acc, w_acc, ar_acc, wr_exec;
    logic [1:0]  wa;
    logic [31:0] wd, rd_mux, lvl_ext;
    logic [3:0]  ws;
    logic [7:0]  lvl_sat;
    logic [8:0]  fifo_head;
    logic [LW-1:0] fifo_level;
    logic        fifo_full, fifo_empty, fifo_s_tready, fifo_m_tvalid, push_req;
    logic        unused_ok;

    // run_q keeps every ready low while in reset and for the first cycle after it.
    assign s00_axi_awready = run_q && !aw_held_q && !bvalid_q;
    assign s00_axi_wready  = run_q && !w_held_q && !bvalid_q;
    assign s00_axi_arready = run_q && !rvalid_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;

    assign aw_acc = s00_axi_awvalid && s00_axi_awready;
    assign w_acc  = s00_axi_wvalid && s00_axi_wready;
    assign ar_acc = s00_axi_arvalid && s00_axi_arready;

    // Execute on the edge that completes the AW/W pair, whichever arrives last.
    assign wr_exec = (aw_acc || w_acc) && (aw_acc || aw_held_q) && (w_acc || w_held_q);
    assign wa = aw_acc ? s00_axi_awaddr[3:2] : awaddr_q;
    assign wd = w_acc ? s00_axi_wdata : wdata_q;
    assign ws = w_acc ? s00_axi_wstrb : wstrb_q;

    assign push_req = wr_exec && (wa == A_CMD) && ws[0];

    lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(9), .LW(LW)) u_fifo (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .s_tdata  (wd[8:0]),
        .s_tvalid (push_req),
        .s_tready (fifo_s_tready),
        .m_tdata  (fifo_head),
        .m_tvalid (fifo_m_tvalid),
        .m_tready (ctrl_en_q && cmd_ready),
        .level    (fifo_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign cmd_valid = ctrl_en_q && fifo_m_tvalid;
    assign cmd_rs    = fifo_head[8];
    assign cmd_data  = fifo_head[7:0];

    assign lvl_ext = 32'(fifo_level);
    assign lvl_sat = (lvl_ext > 32'd255) ? 8'hFF : lvl_ext[7:0];

    always_comb begin
        rd_mux = 32'd0;
        case (s00_axi_araddr[3:2])
            A_STATUS:  rd_mux = {15'd0, ovf_q, lvl_sat, 5'd0, lcd_busy, fifo_full, fifo_empty};
            A_CTRL:    rd_mux = {31'd0, ctrl_en_q};
            A_SCRATCH: rd_mux = scratch_q;
            default:   rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        run_d     = 1'b1;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        ctrl_en_d = ctrl_en_q;
        scratch_d = scratch_q;
        ovf_d     = ovf_q;

        if (bvalid_q && s00_axi_bready) begin
            bvalid_d  = 1'b0;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end else begin
            if (aw_acc) begin
                aw_held_d = 1'b1;
                awaddr_d  = s00_axi_awaddr[3:2];
            end
            if (w_acc) begin
                w_held_d = 1'b1;
                wdata_d  = s00_axi_wdata;
                wstrb_d  = s00_axi_wstrb;
            end
        end

        if (wr_exec) begin
            bvalid_d = 1'b1;
            bresp_d  = 2'b00;
            case (wa)
                A_CMD: if (ws[0] && !fifo_s_tready) begin
                    bresp_d = 2'b10;
                    ovf_d   = 1'b1;
                end
                A_STATUS: if (ws[2] && wd[16]) ovf_d = 1'b0;
                A_CTRL:   if (ws[0]) ctrl_en_d = wd[0];
                default: begin
                    for (int b = 0; b < 4; b++)
                        if (ws[b]) scratch_d[8*b +: 8] = wd[8*b +: 8];
                end
            endcase
        end

        if (rvalid_q && s00_axi_rready) rvalid_d = 1'b0;
        if (ar_acc) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            run_q     <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            ctrl_en_q <= 1'b0;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            run_q     <= run_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            ctrl_en_q <= ctrl_en_d;
            scratch_q <= scratch_d;
            ovf_q     <= ovf_d;
        end
    end

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};
endmodule

// File: doc/lcd_axil_cmd_regs.md
Name: lcd_axil_cmd_regs

Overview:
- AXI4-Lite responder: the slave end of the bus that the LCD bench's write and read tasks drive.
- Decodes a small register map and buffers LCD commands and characters in a FIFO.
- Presents FIFO entries to the LCD timing driver over a valid/ready stream.
- Sits between the PS/interconnect AXI-Lite port and the LCD E/RS/RW sequencer.

Parameters:
- FIFO_DEPTH, 16, command FIFO entries; power of two, 2..256.
- ADDR_WIDTH, 4, AXI address width; only bits [3:2] are decoded.

Ports:
- sys_clk  in  1  clock; all logic on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- s00_axi_awaddr  in  ADDR_WIDTH  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid  in  1  write address valid.
- s00_axi_awready  out  1  write address ready.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte strobes.
- s00_axi_wvalid  in  1  write data valid.
- s00_axi_wready  out  1  write data ready.
- s00_axi_bresp  out  2  write response.
- s00_axi_bvalid  out  1  write response valid.
- s00_axi_bready  in  1  write response ready.
- s00_axi_araddr  in  ADDR_WIDTH  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid  in  1  read address valid.
- s00_axi_arready  out  1  read address ready.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  read response.
- s00_axi_rvalid  out  1  read data valid.
- s00_axi_rready  in  1  read data ready.
- cmd_valid  out  1  FIFO head valid toward the LCD driver.
- cmd_rs  out  1  head RS bit: 0 = instruction, 1 = data.
- cmd_data  out  8  head byte.
- cmd_ready  in  1  driver accepts the head entry.
- lcd_busy  in  1  driver busy; status only.

Behaviour:
- Reset, all outputs 0:
  - awready, wready, bvalid, arready, rvalid = 0; rdata = 0; bresp/rresp = 0.
  - cmd_valid = 0; FIFO empty; CTRL = 0; SCRATCH = 0; overflow flag = 0.
  - Reset mid-transaction drops any pending handshake.
- Register map (addr[3:2]):
  - 0 CMD: write-only; reads return 0.
  - 1 STATUS: read-only. bit0 empty, bit1 full, bit2 lcd_busy, bits[15:8] level (saturates at 255), bit16 overflow (sticky). Writing 1 to bit16 with wstrb[2] set clears the flag.
  - 2 CTRL: bit0 enable; other bits read 0.
  - 3 SCRATCH: 32-bit read/write, byte-lane writes per wstrb.
- Write channel:
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid. Each channel is latched independently, so AW-before-W, W-before-AW and simultaneous arrival are all legal.
  - The register write executes on the edge where the second of AW/W is accepted; bvalid goes to 1 on that same edge.
  - bvalid holds until bready; both held flags clear on that edge.
  - Maximum throughput: one write per 2 cycles.
- CMD write:
  - Pushes {wdata[8], wdata[7:0]} as {rs, data} only when wstrb[0]=1.
  - If the FIFO is full at the execute edge: entry discarded, overflow set, bresp = 2'b10 (SLVERR).
  - A pop on the same edge does not rescue a push to a full FIFO.
  - All other writes return bresp = 0.
- Read channel:
  - arready = !rvalid.
  - On AR handshake, rvalid = 1 on the next edge with rdata from the registers sampled at the AR edge; rresp = 0.
  - rvalid and rdata hold until rready. Maximum throughput: one read per 2 cycles.
  - A read and a write may proceed in the same cycle. A STATUS read on the push edge reflects the pre-push state.
- Stream out:
  - cmd_valid = enable && !empty; cmd_rs and cmd_data are the FIFO head (show-ahead, combinational from memory).
  - Pop on cmd_valid && cmd_ready.
  - Push and pop on the same edge with FIFO not full and not empty: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH; level counter width is log2(FIFO_DEPTH)+1.
  - Clearing enable drops cmd_valid on the next cycle; FIFO contents are retained.

Test Plan:
- Reset then read STATUS -> rdata = 0x00000001 (empty); CTRL and SCRATCH read 0.
- Write SCRATCH = 0xDEADBEEF with AW and W together, then with AW 3 cycles before W, then with W before AW -> bvalid one edge after the last accept, bresp = 0, readback 0xDEADBEEF. Byte write with wstrb = 0010 of 0x11223344 -> 0xDEAD33EF.
- CTRL = 1, cmd_ready = 0; write CMD 0x038 then 0x141 -> STATUS level = 2. With cmd_ready = 1: cmd_valid holds (rs=0, 0x38) then (rs=1, 0x41), then empty.
- CTRL = 0; write 17 CMDs with FIFO_DEPTH = 16 -> 17th bresp = 2'b10; STATUS = 0x00010002 | (16<<8). Write 0x00010000 to STATUS -> bit16 clears.
- FIFO at level 5 with push and pop on the same edge -> level stays 5, data order preserved across pointer wrap.
- Assert sys_rst while bvalid is pending and the FIFO holds 3 entries -> next cycle bvalid = 0, level = 0, cmd_valid = 0.
